// File: rtl/icmp_reply_generator_if.sv
/*----------------------------------------------------------------------------
 * icmp_reply_generator_if : 64-bit AXI4-Stream link carrying the reply frame
 * Revision 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

interface icmp_reply_generator_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/icmp_reply_generator.sv
/*----------------------------------------------------------------------------
 * icmp_reply_generator : builds a 74-byte Ethernet/IPv4/ICMP echo reply
 * Revision 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

module icmp_reply_generator #(
  parameter logic [47:0] BOARD_MAC = 48'h02_00_c0_a8_0a_0a,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd2, 8'd20},
  parameter logic [7:0]  IP_TTL    = 8'h40
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   tx_icmp_en,
  input  logic [47:0]            icmp_src_mac,
  input  logic [31:0]            icmp_src_ip,
  input  logic [15:0]            icmp_src_identifier,
  input  logic [15:0]            icmp_src_sequence_number,
  input  logic [255:0]           icmp_src_data,
  icmp_reply_generator_if.master tx_axis,
  output logic                   busy,
  output logic                   drop_pulse
);

  typedef enum logic [1:0] {IDLE = 2'd0, SUM = 2'd1, FOLD = 2'd2, SEND = 2'd3} state_t;

  state_t        state;
  logic [47:0]   req_mac;
  logic [31:0]   req_ip;
  logic [15:0]   req_id;
  logic [15:0]   req_seq;
  logic [255:0]  req_data;
  logic [15:0]   ip_id;
  logic [31:0]   ip_sum;
  logic [31:0]   icmp_sum;
  logic [15:0]   ip_cksum;
  logic [15:0]   icmp_cksum;
  logic [3:0]    beat;

  logic [31:0]   ip_sum_next;
  logic [31:0]   icmp_sum_next;
  logic [3:0]    load_idx;
  logic [63:0]   load_data;
  logic [7:0]    load_keep;
  logic          load_last;

  function automatic logic [31:0] zx16(input logic [15:0] w);
    return {16'h0000, w};
  endfunction

  // Captured fields are in wire order (low byte first); checksum words are big-endian.
  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [15:0] fold_cksum(input logic [31:0] s);
    logic [31:0] t;
    t = zx16(s[31:16]) + zx16(s[15:0]);
    t = zx16(t[31:16]) + zx16(t[15:0]);
    return ~t[15:0];
  endfunction

  always_comb begin
    ip_sum_next = 32'h0000_4500 + 32'h0000_003C + zx16(ip_id) + zx16({IP_TTL, 8'h01})
                + zx16(BOARD_IP[31:16]) + zx16(BOARD_IP[15:0])
                + zx16(swap16(req_ip[15:0])) + zx16(swap16(req_ip[31:16]));
    icmp_sum_next = zx16(swap16(req_id)) + zx16(swap16(req_seq));
    for (int i = 0; i < 16; i++) begin
      icmp_sum_next = icmp_sum_next + zx16(swap16(req_data[16*i +: 16]));
    end
  end

  // Beat to present next: beat 0 on frame start, otherwise the one after the current beat.
  always_comb begin
    load_idx  = tx_axis.tvalid ? beat + 4'd1 : 4'd0;
    load_data = 64'h0;
    load_keep = 8'hFF;
    load_last = 1'b0;
    case (load_idx)
      4'd0: load_data = {BOARD_MAC[39:32], BOARD_MAC[47:40], req_mac};
      4'd1: load_data = {8'h00, 8'h45, 8'h00, 8'h08,
                         BOARD_MAC[7:0], BOARD_MAC[15:8], BOARD_MAC[23:16], BOARD_MAC[31:24]};
      4'd2: load_data = {8'h01, IP_TTL, 8'h00, 8'h00, ip_id[7:0], ip_id[15:8], 8'h3C, 8'h00};
      4'd3: load_data = {req_ip[15:8], req_ip[7:0],
                         BOARD_IP[7:0], BOARD_IP[15:8], BOARD_IP[23:16], BOARD_IP[31:24],
                         ip_cksum[7:0], ip_cksum[15:8]};
      4'd4: load_data = {req_id, icmp_cksum[7:0], icmp_cksum[15:8], 8'h00, 8'h00,
                         req_ip[31:24], req_ip[23:16]};
      4'd5: load_data = {req_data[47:0], req_seq};
      4'd6: load_data = req_data[111:48];
      4'd7: load_data = req_data[175:112];
      4'd8: load_data = req_data[239:176];
      4'd9: begin
        load_data = {48'h0, req_data[255:240]};
        load_keep = 8'h03;
        load_last = 1'b1;
      end
      default: load_keep = 8'h00;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      req_mac        <= '0;
      req_ip         <= '0;
      req_id         <= '0;
      req_seq        <= '0;
      req_data       <= '0;
      ip_id          <= '0;
      ip_sum         <= '0;
      icmp_sum       <= '0;
      ip_cksum       <= '0;
      icmp_cksum     <= '0;
      beat           <= '0;
      busy           <= 1'b0;
      drop_pulse     <= 1'b0;
      tx_axis.tdata  <= '0;
      tx_axis.tkeep  <= '0;
      tx_axis.tvalid <= 1'b0;
      tx_axis.tlast  <= 1'b0;
    end else begin
      drop_pulse <= tx_icmp_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (tx_icmp_en) begin
            req_mac  <= icmp_src_mac;
            req_ip   <= icmp_src_ip;
            req_id   <= icmp_src_identifier;
            req_seq  <= icmp_src_sequence_number;
            req_data <= icmp_src_data;
            busy     <= 1'b1;
            state    <= SUM;
          end
        end
        SUM: begin
          ip_sum   <= ip_sum_next;
          icmp_sum <= icmp_sum_next;
          state    <= FOLD;
        end
        FOLD: begin
          ip_cksum   <= fold_cksum(ip_sum);
          icmp_cksum <= fold_cksum(icmp_sum);
          state      <= SEND;
        end
        SEND: begin
          if (!tx_axis.tvalid) begin
            tx_axis.tvalid <= 1'b1;
            tx_axis.tdata  <= load_data;
            tx_axis.tkeep  <= load_keep;
            tx_axis.tlast  <= load_last;
            beat           <= 4'd0;
          end else if (tx_axis.tready) begin
            if (beat == 4'd9) begin
              tx_axis.tvalid <= 1'b0;
              tx_axis.tdata  <= '0;
              tx_axis.tkeep  <= '0;
              tx_axis.tlast  <= 1'b0;
              ip_id          <= ip_id + 16'd1;
              busy           <= 1'b0;
              state          <= IDLE;
            end else begin
              beat          <= beat + 4'd1;
              tx_axis.tdata <= load_data;
              tx_axis.tkeep <= load_keep;
              tx_axis.tlast <= load_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
